// File: rtl/sh_mem_banked.sv
// ---------------------------------------------------------------------------
// sh_mem_banked
//   Banked shared memory for the DSP/GPU core cluster. Every core can issue
//   one read or write per cycle; each bank has its own round-robin arbiter
//   that accepts at most one core per cycle. Read data comes back on a
//   separate per-core valid strobe, so a core never has to infer data timing
//   from its grant.
//
// Parameters
//   NUM_CORES  : number of requesting cores (>= 2)
//   NUM_BANKS  : number of banks (power of two, >= 2)
//   BANK_WORDS : words per bank (power of two)
//   DATA_W     : word width in bits
//   BANK_ID_W, WORD_ID_W, ADDR_W are derived and cannot be overridden.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   reset    : asynchronous, active-high reset
//   enable   : per-core op {wr,rd}; 00 idle, 01 read, 10 write, 11 illegal
//   addr     : per-core {bank_id, word_id}
//   wr_data  : per-core write word
//   grant    : combinational; the core's request is accepted this cycle
//   rd_valid : registered; the core's rd_data slice is valid
//   rd_data  : per-core read word, zero whenever rd_valid is low
//
// Build option
//   SH_MEM_RD_REG_EN : when defined, adds a reset-cleared output register on
//                      rd_data/rd_valid, so read latency becomes 2 cycles
//                      instead of 1. Grant behaviour does not change.
// ---------------------------------------------------------------------------
module sh_mem_banked #(
  parameter  int NUM_CORES  = 4,
  parameter  int NUM_BANKS  = 4,
  parameter  int BANK_WORDS = 256,
  parameter  int DATA_W     = 8,
  localparam int BANK_ID_W  = $clog2(NUM_BANKS),
  localparam int WORD_ID_W  = $clog2(BANK_WORDS),
  localparam int ADDR_W     = BANK_ID_W + WORD_ID_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2*NUM_CORES-1:0]      enable,
  input  logic [ADDR_W*NUM_CORES-1:0] addr,
  input  logic [DATA_W*NUM_CORES-1:0] wr_data,
  output logic [NUM_CORES-1:0]        grant,
  output logic [NUM_CORES-1:0]        rd_valid,
  output logic [DATA_W*NUM_CORES-1:0] rd_data
);

  localparam int         CORE_ID_W = $clog2(NUM_CORES);
  localparam logic [1:0] OP_RD     = 2'b01;
  localparam logic [1:0] OP_WR     = 2'b10;

  logic [1:0]           w_op         [NUM_CORES];
  logic [BANK_ID_W-1:0] w_coreBank   [NUM_CORES];
  logic [WORD_ID_W-1:0] w_coreWord   [NUM_CORES];
  logic [DATA_W-1:0]    w_coreData   [NUM_CORES];
  logic [NUM_CORES-1:0] w_reqMask    [NUM_BANKS];
  logic [NUM_BANKS-1:0] w_bankHit;
  logic [CORE_ID_W-1:0] w_bankWinner [NUM_BANKS];
  logic [NUM_CORES-1:0] w_grant;
  logic [NUM_CORES-1:0] w_rdFire;
  logic [DATA_W*NUM_CORES-1:0] w_rdPacked;

  logic [CORE_ID_W-1:0] r_last   [NUM_BANKS];
  logic [DATA_W-1:0]    r_mem    [NUM_BANKS][BANK_WORDS];
  logic [NUM_CORES-1:0] r_rdValid;
  logic [DATA_W-1:0]    r_rdData [NUM_CORES];

  // Split the flat per-core buses into op, bank, word and data fields.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      w_op[i]       = enable[2*i +: 2];
      w_coreWord[i] = addr[i*ADDR_W +: WORD_ID_W];
      w_coreBank[i] = addr[i*ADDR_W + WORD_ID_W +: BANK_ID_W];
      w_coreData[i] = wr_data[i*DATA_W +: DATA_W];
    end
  end

  // Bank decode: only genuine reads and writes request a bank; the illegal
  // op 11 is treated as idle so it can never win or move a pointer.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_reqMask[b] = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        w_reqMask[b][i] = ((w_op[i] == OP_RD) || (w_op[i] == OP_WR)) &&
                          (w_coreBank[i] == BANK_ID_W'(b));
      end
    end
  end

  // Round-robin search per bank, starting one past the last winner and
  // wrapping around, so every contender is served within NUM_CORES-1 waits.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bankHit[b]    = 1'b0;
      w_bankWinner[b] = '0;
      for (int k = 1; k <= NUM_CORES; k++) begin
        if (!w_bankHit[b] &&
            w_reqMask[b][CORE_ID_W'((int'(r_last[b]) + k) % NUM_CORES)]) begin
          w_bankHit[b]    = 1'b1;
          w_bankWinner[b] = CORE_ID_W'((int'(r_last[b]) + k) % NUM_CORES);
        end
      end
    end
  end

  // A core addresses exactly one bank, so OR-ing the bank winners gives at
  // most one grant per core. Reset forces every grant low.
  always_comb begin
    w_grant = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_bankHit[b] && (w_bankWinner[b] == CORE_ID_W'(i))) begin
          w_grant[i] = 1'b1;
        end
      end
    end
    if (reset) begin
      w_grant = '0;
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      w_rdFire[i] = w_grant[i] && (w_op[i] == OP_RD);
    end
  end

  assign grant = w_grant;

  // Pointer update, bank writes and the per-core read register. The read
  // register is forced to zero on cycles without a granted read so rd_data
  // is zero whenever rd_valid is low. Reset clears memory and drops any
  // read that was in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_last[b] <= CORE_ID_W'(NUM_CORES - 1);
        for (int w = 0; w < BANK_WORDS; w++) begin
          r_mem[b][w] <= '0;
        end
      end
      r_rdValid <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        r_rdData[i] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_bankHit[b]) begin
          r_last[b] <= w_bankWinner[b];
          if (w_op[w_bankWinner[b]] == OP_WR) begin
            r_mem[b][w_coreWord[w_bankWinner[b]]] <= w_coreData[w_bankWinner[b]];
          end
        end
      end
      r_rdValid <= w_rdFire;
      for (int i = 0; i < NUM_CORES; i++) begin
        r_rdData[i] <= w_rdFire[i] ? r_mem[w_coreBank[i]][w_coreWord[i]] : '0;
      end
    end
  end

  // Pack the per-core read words back onto the flat output bus.
  always_comb begin
    w_rdPacked = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_rdPacked[i*DATA_W +: DATA_W] = r_rdData[i];
    end
  end

`ifdef SH_MEM_RD_REG_EN
  logic [NUM_CORES-1:0]        r_outValid;
  logic [DATA_W*NUM_CORES-1:0] r_outData;

  // Extra output stage for timing margin on the read return path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outValid <= '0;
      r_outData  <= '0;
    end else begin
      r_outValid <= r_rdValid;
      r_outData  <= w_rdPacked;
    end
  end

  assign rd_valid = r_outValid;
  assign rd_data  = r_outData;
`else
  assign rd_valid = r_rdValid;
  assign rd_data  = w_rdPacked;
`endif

endmodule

// File: tb/tb_sh_mem_banked.sv
`timescale 1ns/1ps
module tb_sh_mem_banked;

  localparam int NC = 4;
  localparam int DW = 8;
  localparam int AW = 10;
`ifdef SH_MEM_RD_REG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [2*NC-1:0]  enable = '0;
  logic [AW*NC-1:0] addr = '0;
  logic [DW*NC-1:0] wr_data = '0;
  logic [NC-1:0]    grant;
  logic [NC-1:0]    rd_valid;
  logic [DW*NC-1:0] rd_data;

  int numChecks = 0;
  int numFails  = 0;

  sh_mem_banked dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .addr     (addr),
    .wr_data  (wr_data),
    .grant    (grant),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    assert (observed === expected) else begin
      numFails++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one core's request slice.
  task automatic applyStimulus(input int core, input logic [1:0] op,
                               input logic [1:0] bank, input logic [7:0] word,
                               input logic [7:0] data);
    enable[2*core +: 2]   = op;
    addr[AW*core +: AW]   = {bank, word};
    wr_data[DW*core +: DW] = data;
  endtask

  task automatic clearAll();
    enable  = '0;
    addr    = '0;
    wr_data = '0;
  endtask

  // Move to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Outputs held at zero during the initial reset.
    #1;
    checkOutput("reset_grant",    32'(grant),    32'h0);
    checkOutput("reset_rd_valid", 32'(rd_valid), 32'h0);
    checkOutput("reset_rd_data",  32'(rd_data),  32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Core 0 reads, then reset hits mid-cycle with the read in flight.
    tick();
    applyStimulus(0, OP_RD, 2'd0, 8'd0, 8'h00);
    #1;
    checkOutput("inflight_grant", 32'(grant), 32'h1);
    tick();
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midreset_grant",    32'(grant),    32'h0);
    checkOutput("midreset_rd_valid", 32'(rd_valid), 32'h0);
    checkOutput("midreset_rd_data",  32'(rd_data),  32'h0);
    tick();
    tick();
    @(negedge clk);
    clearAll();
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      checkOutput("postreset_no_pulse", 32'(rd_valid), 32'h0);
    end

    // Full contention on bank 0 starting from reset: strict order 0,1,2,3.
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < NC; c++) applyStimulus(c, OP_RD, 2'd0, 8'(c), 8'h00);
    #1;
    checkOutput("contend_reset_grant", 32'(grant), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("contend_grant_0", 32'(grant), 32'h1);
    for (int k = 1; k < 8; k++) begin
      tick();
      checkOutput("contend_grant", 32'(grant), 32'(1) << (k % NC));
      if (k >= RD_LAT) begin
        checkOutput("contend_rd_valid", 32'(rd_valid), 32'(1) << ((k - RD_LAT) % NC));
      end
    end
    tick();
    clearAll();
    repeat (3) tick();

    // Single write then read: core 1, bank 2, word 7, 0xA5.
    applyStimulus(1, OP_WR, 2'd2, 8'd7, 8'hA5);
    #1;
    checkOutput("single_wr_grant", 32'(grant), 32'h2);
    tick();
    clearAll();
    applyStimulus(1, OP_RD, 2'd2, 8'd7, 8'h00);
    #1;
    checkOutput("single_rd_grant", 32'(grant), 32'h2);
    tick();
    clearAll();
    repeat (RD_LAT - 1) tick();
    checkOutput("single_rd_valid", 32'(rd_valid), 32'h2);
    checkOutput("single_rd_data",  32'(rd_data),  32'h0000A500);
    tick();
    checkOutput("single_pulse_end", 32'(rd_valid), 32'h0);
    checkOutput("single_data_zero", 32'(rd_data),  32'h0);

    // Parallel banks: every core hits its own bank in the same cycle.
    tick();
    for (int c = 0; c < NC; c++) applyStimulus(c, OP_WR, 2'(c), 8'd5, 8'(8'h10 + c));
    #1;
    checkOutput("parallel_wr_grant", 32'(grant), 32'hF);
    tick();
    for (int c = 0; c < NC; c++) applyStimulus(c, OP_RD, 2'(c), 8'd5, 8'h00);
    #1;
    checkOutput("parallel_rd_grant", 32'(grant), 32'hF);
    tick();
    clearAll();
    repeat (RD_LAT - 1) tick();
    checkOutput("parallel_rd_valid", 32'(rd_valid), 32'hF);
    checkOutput("parallel_rd_data",  32'(rd_data),  32'h13121110);

    // Illegal op on bank 1 is never granted and leaves the pointer alone.
    tick();
    clearAll();
    applyStimulus(2, OP_BAD, 2'd1, 8'd3, 8'h77);
    #1;
    checkOutput("illegal_grant_a", 32'(grant), 32'h0);
    tick();
    checkOutput("illegal_grant_b",  32'(grant),    32'h0);
    checkOutput("illegal_rd_valid", 32'(rd_valid), 32'h0);
    tick();
    clearAll();
    applyStimulus(2, OP_RD, 2'd1, 8'd0, 8'h00);
    applyStimulus(3, OP_RD, 2'd1, 8'd0, 8'h00);
    #1;
    checkOutput("illegal_ptr_held", 32'(grant), 32'h4);
    tick();
    clearAll();
    applyStimulus(3, OP_RD, 2'd1, 8'd3, 8'h00);
    #1;
    checkOutput("illegal_word_grant", 32'(grant), 32'h8);
    tick();
    clearAll();
    repeat (RD_LAT - 1) tick();
    checkOutput("illegal_word_valid", 32'(rd_valid), 32'h8);
    checkOutput("illegal_word_data",  32'(rd_data),  32'h0);

    // Withdrawal: core 3's write loses arbitration, then is dropped.
    tick();
    applyStimulus(0, OP_RD, 2'd3, 8'd1, 8'h00);
    applyStimulus(3, OP_WR, 2'd3, 8'd9, 8'hEE);
    #1;
    checkOutput("withdraw_contend", 32'(grant), 32'h1);
    tick();
    clearAll();
    #1;
    checkOutput("withdraw_idle", 32'(grant), 32'h0);
    tick();
    applyStimulus(3, OP_RD, 2'd3, 8'd9, 8'h00);
    #1;
    checkOutput("withdraw_rd_grant", 32'(grant), 32'h8);
    tick();
    clearAll();
    repeat (RD_LAT - 1) tick();
    checkOutput("withdraw_rd_valid", 32'(rd_valid), 32'h8);
    checkOutput("withdraw_rd_data",  32'(rd_data),  32'h0);

    // Back-to-back read-after-write across cores on bank 3 word 0.
    tick();
    applyStimulus(0, OP_WR, 2'd3, 8'd0, 8'h3C);
    #1;
    checkOutput("raw_wr_grant", 32'(grant), 32'h1);
    tick();
    clearAll();
    applyStimulus(1, OP_RD, 2'd3, 8'd0, 8'h00);
    #1;
    checkOutput("raw_rd_grant", 32'(grant), 32'h2);
    tick();
    clearAll();
    repeat (RD_LAT - 1) tick();
    checkOutput("raw_rd_valid", 32'(rd_valid), 32'h2);
    checkOutput("raw_rd_data",  32'(rd_data),  32'h00003C00);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
